// File: rtl/program_loader.sv
// Program loader: takes a framed byte stream (SYNC, LEN_LO, LEN_HI, 4*N data bytes, CSUM)
//   and writes the image word by word into the program ROM, holding the CPU in reset until verified.
// Latency: mem_we pulses exactly 1 cycle after the handshake of each word's 4th byte; done/cpu_hold
//   update 1 cycle after the CSUM handshake.
// Backpressure: in_ready is high in every state except DONE (from state only, never from in_valid).
// Ports: clk, reset (sync, active-high) | in_data/in_valid/in_ready byte stream |
//   mem_we/mem_addr/mem_wdata ROM write port | cpu_hold, done, error status.
module program_loader #(
  parameter int          PROGRAM_MEMORY_SIZE_WORDS = 1024,
  parameter int          ADDR_WIDTH                = 10,
  parameter logic [7:0]  SYNC_BYTE                 = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] asm_word;   // lower three bytes of the word being assembled

  logic        accept;
  logic [15:0] len_full;
  logic [31:0] len_ext;
  logic        len_bad;

  // Reset is OR'd in so in_ready reads 1 during reset even before the state register is known.
  assign in_ready = reset || (state != S_DONE);
  assign accept   = in_valid && in_ready;

  // Length candidate formed from the byte currently on the bus plus the latched low byte.
  assign len_full = {in_data, len_lo};
  assign len_ext  = {16'd0, len_full};
  assign len_bad  = (len_full == 16'd0) || (len_ext > 32'(PROGRAM_MEMORY_SIZE_WORDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_lo    <= 8'd0;
      word_cnt  <= 16'd0;
      word_idx  <= 16'd0;
      byte_idx  <= 2'd0;
      csum      <= 8'd0;
      asm_word  <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; address and data hold between writes.
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            word_cnt <= len_full;
            if (len_bad) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state    <= S_DATA;
              word_idx <= 16'd0;
              byte_idx <= 2'd0;
              csum     <= 8'd0;
            end
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= in_data;
              2'd1: asm_word[15:8]  <= in_data;
              2'd2: asm_word[23:16] <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                mem_wdata <= {in_data, asm_word};
                word_idx  <= word_idx + 16'd1;
                if (word_idx == word_cnt - 16'd1) state <= S_CSUM;
              end
            endcase
          end
          S_CSUM: begin
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
          S_ERROR: begin
            // Only a fresh sync restarts the load; anything else is dropped.
            if (in_data == SYNC_BYTE) begin
              error <= 1'b0;
              state <= S_LEN_LO;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int MEMW = 1024;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  // Marks the byte currently driven as the 4th byte of a data word.
  logic          lw = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    int n;
    int kind;      // 0: fixed two-word program, 1: word = index, 2: random
    bit bad;       // corrupt the checksum
    bit gaps;      // random in_valid=0 gaps
    bit junk;      // leading 13 FF bytes before the frame
    bit retry;     // resend a good frame afterwards
    bit exp_done;
    bit exp_err;
  } vec_t;

  program_loader #(
    .PROGRAM_MEMORY_SIZE_WORDS(MEMW),
    .ADDR_WIDTH(AW),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples 2 time units before each rising edge.
  task automatic monitor();
    bit  hs_prev = 1'b0;
    wr_t e;
    forever begin
      @(negedge clk);
      #3;
      if (hs_prev || mem_we) begin
        chk("mem_we_timing", {31'd0, mem_we}, {31'd0, hs_prev});
        if (mem_we) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", {22'd0, mem_addr}, e.addr);
            chk("wr_data", mem_wdata, e.data);
          end
        end
      end
      hs_prev = in_valid && in_ready && lw && !reset;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      lw = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last4, input bit gap);
    int waits;
    if (gap) idle($urandom_range(0, 3));
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    lw       = last4;
    waits    = 0;
    while (!in_ready) begin
      if (waits >= 50) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout byte=%h in_ready=%b required=1", b, in_ready);
        in_valid = 1'b0;
        lw = 1'b0;
        return;
      end
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int kind, input bit bad, input bit gaps);
    logic [31:0] w;
    logic [7:0]  cs;
    logic [15:0] n16;
    wr_t         e;
    cs  = 8'd0;
    n16 = 16'(n);
    send_byte(8'hA5, 1'b0, gaps);
    send_byte(n16[7:0], 1'b0, gaps);
    send_byte(n16[15:8], 1'b0, gaps);
    for (int i = 0; i < n; i++) begin
      if (kind == 0)      w = (i == 0) ? 32'h0050_0093 : 32'h0000_0013;
      else if (kind == 1) w = 32'(i);
      else                w = $urandom;
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_byte(w[7:0],   1'b0, gaps);
      send_byte(w[15:8],  1'b0, gaps);
      send_byte(w[23:16], 1'b0, gaps);
      e.addr = 32'(i);
      e.data = w;
      sb.push_back(e);
      send_byte(w[31:24], 1'b1, gaps);
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, 1'b0, gaps);
    idle(3);
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    lw       = 1'b0;
    @(negedge clk);
    if (check_vals) begin
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_cpu_hold",  {31'd0, cpu_hold}, 32'd1);
      chk("rst_done",      {31'd0, done},     32'd0);
      chk("rst_error",     {31'd0, error},    32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},   32'd0);
      chk("rst_mem_addr",  {22'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata,         32'd0);
    end
    reset = 1'b0;
  endtask

  task automatic status(input string tag, input bit d, input bit er);
    chk({tag, "_done"},     {31'd0, done},     {31'd0, d});
    chk({tag, "_error"},    {31'd0, error},    {31'd0, er});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !d});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !d});
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{n: 2,    kind: 0, bad: 0, gaps: 0, junk: 0, retry: 0, exp_done: 1, exp_err: 0};
    vecs[1] = '{n: 2,    kind: 0, bad: 1, gaps: 0, junk: 0, retry: 1, exp_done: 0, exp_err: 1};
    vecs[2] = '{n: 2,    kind: 0, bad: 0, gaps: 1, junk: 1, retry: 0, exp_done: 1, exp_err: 0};
    vecs[3] = '{n: 5,    kind: 2, bad: 0, gaps: 1, junk: 0, retry: 0, exp_done: 1, exp_err: 0};
    vecs[4] = '{n: 3,    kind: 2, bad: 1, gaps: 1, junk: 1, retry: 0, exp_done: 0, exp_err: 1};
    vecs[5] = '{n: MEMW, kind: 1, bad: 0, gaps: 0, junk: 0, retry: 0, exp_done: 1, exp_err: 0};

    fork
      monitor();
    join_none

    // Reset state straight out of power-up.
    do_reset(1'b1);

    foreach (vecs[i]) begin
      do_reset(1'b0);
      if (vecs[i].junk) begin
        send_byte(8'h13, 1'b0, vecs[i].gaps);
        send_byte(8'hFF, 1'b0, vecs[i].gaps);
      end
      send_frame(vecs[i].n, vecs[i].kind, vecs[i].bad, vecs[i].gaps);
      status($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err);
      if (vecs[i].retry) begin
        send_frame(vecs[i].n, vecs[i].kind, 1'b0, vecs[i].gaps);
        status($sformatf("vec%0d_retry", i), 1'b1, 1'b0);
      end
    end

    // Reset out of DONE after a full-size image: address/data registers must clear.
    do_reset(1'b1);

    // Zero-length frame.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    idle(2);
    status("len0", 1'b0, 1'b1);

    // Sync in ERROR clears error and restarts length parsing.
    send_byte(8'hA5, 1'b0, 1'b0);
    idle(2);
    chk("resync_error_clear", {31'd0, error}, 32'd0);

    // Oversize length (MEMW+1 = 0x0401), then stray bytes that must not write.
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    idle(2);
    status("len_over", 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    idle(3);
    status("err_discard", 1'b0, 1'b1);

    // Reset after six bytes of the reference frame, then a full resend.
    do_reset(1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h93, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h50, 1'b0, 1'b0);
    do_reset(1'b1);
    send_frame(2, 0, 1'b0, 1'b0);
    status("after_midreset", 1'b1, 1'b0);

    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
